// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Holds the FSM state encoding, the burst counter width and the default burst limit.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam int MAX_BURST_DEFAULT = 4;
    localparam int CNT_W             = 3;

    // Saturating increment of the burst counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v < lim) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of requester-side and SRAM-side signals of the arbiter.
// slave = arbiter view, master = requesters plus SRAM macro view.
interface sram_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              mem_cs, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_cs, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sram_arb_fsm.sv
// Grant decision for two requesters: round-robin on ties from IDLE,
// bursts capped at MAX_BURST while the other side is waiting.
module sram_arb_fsm
    import sram_arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BURST);

    arb_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last, last_nxt;
    logic             give, sel;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
        end
    end

    // NOTE: every output of this block is assigned a default first, so no
    // path through the case can leave a value held and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        give      = 1'b0;
        sel       = 1'b0;

        unique case (state)
            IDLE: begin
                give = req0 | req1;
                sel  = (req0 & req1) ? ~last : req1;
            end
            OWN0: begin
                if (req0 && (cnt < MAX_C || !req1)) begin
                    give = 1'b1;
                    sel  = 1'b0;
                end else if (req1) begin
                    give = 1'b1;
                    sel  = 1'b1;
                end
            end
            OWN1: begin
                if (req1 && (cnt < MAX_C || !req0)) begin
                    give = 1'b1;
                    sel  = 1'b1;
                end else if (req0) begin
                    give = 1'b1;
                    sel  = 1'b0;
                end
            end
            default: ;
        endcase

        if (give) begin
            last_nxt  = sel;
            state_nxt = sel ? OWN1 : OWN0;
            // Staying with the same owner extends the burst; a new owner restarts it.
            cnt_nxt   = (state == state_nxt) ? sat_inc(cnt, MAX_C) : CNT_W'(1);
        end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end

        gnt0 = give & ~sel & ~reset;
        gnt1 = give &  sel & ~reset;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester single-port SRAM arbiter: muxes the granted request onto
// the SRAM pins and flags returning read data to its owner one cycle later.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    sram_arbiter_if.slave   bus
);

    logic              gnt0, gnt1;
    logic              we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              rvalid0_q, rvalid1_q;

    sram_arb_fsm #(
        .MAX_BURST(MAX_BURST)
    ) u_fsm (
        .clk  (clk),
        .reset(reset),
        .req0 (bus.req0),
        .req1 (bus.req1),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    always_comb begin
        we_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        if (gnt0) begin
            we_sel    = bus.we0;
            addr_sel  = bus.addr0;
            wdata_sel = bus.wdata0;
        end else if (gnt1) begin
            we_sel    = bus.we1;
            addr_sel  = bus.addr1;
            wdata_sel = bus.wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt0 & ~bus.we0;
            rvalid1_q <= gnt1 & ~bus.we1;
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.mem_cs    = gnt0 | gnt1;
    assign bus.mem_we    = we_sel;
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = wdata_sel;
    assign bus.rdata     = bus.mem_rdata;
    // A read issued just before a reset must not report valid data during that reset cycle.
    assign bus.rvalid0   = rvalid0_q & ~reset;
    assign bus.rvalid1   = rvalid1_q & ~reset;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4: SRAM address width (16 words).
REQ-002 Parameter DATA_W, default 8: SRAM data width.
REQ-003 Parameter MAX_BURST, default 4: max consecutive grants to one owner while the other requests.
REQ-004 CLK  input  1  sole clock, all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-006 Req0, Req1  input  1 each  access request, held high until granted.
REQ-007 We0, We1  input  1 each  1 = write, 0 = read, valid while Req high.
REQ-008 Addr0, Addr1  input  ADDR_W each  access address, valid while Req high.
REQ-009 Wdata0, Wdata1  input  DATA_W each  write data, valid while Req and We high.
REQ-010 Gnt0, Gnt1  output  1 each  combinational, high in the cycle the requester's access is issued to SRAM.
REQ-011 Rvalid0, Rvalid1  output  1 each  registered, high one cycle after a read grant to that requester.
REQ-012 Rdata  output  DATA_W  shared read data, equals Mem_Rdata, qualified by Rvalid0/Rvalid1.
REQ-013 Mem_CS, Mem_WE  output  1 each  SRAM chip select / write enable, combinational.
REQ-014 Mem_Addr, Mem_Wdata  output  ADDR_W / DATA_W  muxed from granted requester; zero when no grant.
REQ-015 Mem_Rdata  input  DATA_W  SRAM read data, valid one cycle after read issue.

Function
REQ-016 State machine states: IDLE, OWN0, OWN1; 3-bit burst counter Cnt (0..MAX_BURST); 1-bit Last pointer (last owner).
REQ-017 At most one of Gnt0/Gnt1 high per cycle; Mem_CS = Gnt0 | Gnt1; Mem_WE = Mem_CS & We of granted requester.
REQ-018 IDLE: only Req0 -> grant 0, next OWN0, Cnt=1; only Req1 -> grant 1, next OWN1, Cnt=1; both -> grant the requester != Last; none -> no grant, stay IDLE.
REQ-019 OWNk: Req_k high and (Cnt < MAX_BURST or other Req low) -> grant k, Cnt = min(Cnt+1, MAX_BURST), stay OWNk.
REQ-020 OWNk: otherwise, other Req high -> grant other, next OWN_other, Cnt=1.
REQ-021 OWNk: neither Req high -> no grant, next IDLE, Cnt=0.
REQ-022 Last updates to the granted index on every grant; unchanged on no-grant cycles.
REQ-023 Throughput: one access per cycle; switching owners costs no idle cycle.
REQ-024 Read latency: Rvalid_k high exactly one cycle after the Gnt_k cycle with We_k=0; writes never raise Rvalid.
REQ-025 Requester deasserts Req the cycle after Gnt if it has no further access; Req still high after Gnt is a new request.

Reset
REQ-026 Reset high: next state IDLE, Cnt=0, Last=1 (so Req0 wins first tie), Rvalid0=Rvalid1=0.
REQ-027 During the Reset cycle Gnt0, Gnt1, Mem_CS, Mem_WE are forced 0 regardless of requests.
REQ-028 Reset in the cycle after a read grant suppresses that pending Rvalid.

Structure
REQ-029 State encoding (IDLE=0, OWN0=1, OWN1=2) and MAX_BURST default go in a shared package sram_arb_pkg.
REQ-030 One sub-module sram_arb_fsm holds state, Cnt, Last and grant decision; top holds muxes and Rvalid registers.

Verification
REQ-031 Reset, then Req0 write Addr=3 Wdata=0xA5 -> Gnt0 same cycle, Mem_WE=1, Mem_Addr=3, Mem_Wdata=0xA5; Rvalid0 stays 0.
REQ-032 Req1 read Addr=3 after REQ-031 write -> Gnt1, next cycle Rvalid1=1, Rdata=0xA5, Rvalid0=0.
REQ-033 Both Req from IDLE after reset -> Gnt0 first; both held continuously -> Gnt0 x4, then Gnt1 x4, then Gnt0, alternating in bursts of 4.
REQ-034 Req0 alone held 10 cycles -> Gnt0 all 10 cycles, no gaps, Cnt saturates at 4.
REQ-035 Read grant to Req0 then Reset next cycle -> Rvalid0 never asserts, state IDLE, Last=1.
REQ-036 Random two-requester traffic against a 16x8 SRAM model -> every read returns last written value, never two grants in one cycle, no requester waits more than MAX_BURST cycles.
